// File: rtl/pwm_pkg.sv
// pwm_pkg -- constants and types shared by the PWM blocks.
//   CNT_W / CNT_MAX : width and saturation value of the capture counters.
//   state_e         : capture FSM state encoding.
//   GEN_*           : settings of the existing PWM generator.
//   cnt_inc()       : counter increment that never wraps past CNT_MAX.
package pwm_pkg;

    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    // PWM generator: free-running counter 0..GEN_PERIOD-1,
    // output high while the count is below GEN_THRESHOLD.
    localparam int GEN_PERIOD    = 1000;
    localparam int GEN_THRESHOLD = 250;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? CNT_MAX : cnt + 10'd1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge -- brings an asynchronous level into the clk domain and flags
// its edges.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset, clears all three flops
//   d_i     : asynchronous input level
//   level_o : synchronized level (s2)
//   rise_o  : s2 & ~s3, one cycle per rising edge
//   fall_o  : ~s2 & s3, one cycle per falling edge
module sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // sync_q[0] = s1 (metastability catcher), sync_q[1] = s2, sync_q[2] = s3
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    assign sync_d = {sync_q[1], sync_q[0], d_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level_o = sync_q[1];
    // s3 resets to 0, so an input already high at reset release shows up
    // as a rise.
    assign rise_o  =  sync_q[1] & ~sync_q[2];
    assign fall_o  = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture -- measures period and high-time of an external PWM signal.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   pwm_in  : PWM input, asynchronous to clk
//   duty    : high cycles of the last complete period
//   period  : length of the last complete period in clk cycles
//   valid   : one-cycle pulse when duty/period are refreshed
//   timeout : sticky, set when no period completes within CNT_MAX cycles;
//             cleared by the next valid measurement
module pwm_capture
    import pwm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             timeout
);

    logic s2_lvl;
    logic rise;
    logic fall;

    sync_edge u_sync_edge (
        .clk_i   (clk),
        .rst_ni  (reset),
        .d_i     (pwm_in),
        .level_o (s2_lvl),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    state_e           state_q;
    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] high_cnt_q;
    logic [CNT_W-1:0] duty_q;
    logic [CNT_W-1:0] period_q;
    logic             valid_q;
    logic             timeout_q;

    logic [CNT_W-1:0] per_cnt_d;
    logic [CNT_W-1:0] high_cnt_d;

    assign per_cnt_d  = cnt_inc(per_cnt_q);
    assign high_cnt_d = cnt_inc(high_cnt_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            per_cnt_q  <= '0;
            high_cnt_q <= '0;
            duty_q     <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The rise cycle itself is the first cycle of the period.
                    if (rise) begin
                        per_cnt_q  <= 10'd1;
                        high_cnt_q <= 10'd1;
                        state_q    <= HIGH;
                    end
                end
                HIGH: begin
                    // A rise cannot occur while s2 is already high, so a full
                    // counter here always means saturation.
                    if (per_cnt_q == CNT_MAX) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else if (fall) begin
                        // s2 is already low in the fall cycle: not counted as high.
                        per_cnt_q <= per_cnt_d;
                        state_q   <= LOW;
                    end else begin
                        per_cnt_q <= per_cnt_d;
                        if (s2_lvl) begin
                            high_cnt_q <= high_cnt_d;
                        end
                    end
                end
                LOW: begin
                    if (rise) begin
                        // The rise cycle closes this period and opens the next.
                        duty_q     <= high_cnt_q;
                        period_q   <= per_cnt_q;
                        valid_q    <= 1'b1;
                        timeout_q  <= 1'b0;
                        per_cnt_q  <= 10'd1;
                        high_cnt_q <= 10'd1;
                        state_q    <= HIGH;
                    end else if (per_cnt_q == CNT_MAX) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        per_cnt_q <= per_cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign duty    = duty_q;
    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule
